// File: rtl/tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tx_frame_arbiter
// Description : Round-robin arbiter that grants one virtual-channel queue at
//               a time to a shared TX port. A frame is sent without
//               interruption until end of frame, then a fixed inter-frame gap
//               is inserted before the next arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_frame_arbiter #(
    parameter int P_NUM_REQ    = 3,
    parameter int P_IFG_CYCLES = 12
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [P_NUM_REQ-1:0] req_i,
    input  logic [P_NUM_REQ-1:0] eof_i,
    output logic [P_NUM_REQ-1:0] grant_o,
    output logic [P_NUM_REQ-1:0] pop_o,
    output logic                 tx_ctrl_o,
    output logic                 busy_o,
    output logic [15:0]          frame_cnt_o
);

    localparam int IDX_W = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    // Gap counter counts down to zero inclusive, so it is loaded one short.
    localparam logic [7:0]       IFG_LOAD = 8'(P_IFG_CYCLES - 1);
    // Reset priority pointer sits on the top queue so queue 0 is searched first.
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(P_NUM_REQ - 1);

    logic [1:0]           state_q,     state_d;
    logic [P_NUM_REQ-1:0] grant_q,     grant_d;
    logic [7:0]           gap_cnt_q,   gap_cnt_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic [IDX_W-1:0]     last_q,      last_d;

    logic                 w_win_found;
    logic [IDX_W-1:0]     w_win_idx;
    logic [P_NUM_REQ-1:0] w_win_onehot;
    int                   w_best;
    int                   w_dist;

    // Round-robin pick: the requester with the smallest upward distance from
    // the slot after the last winner wins.
    always_comb begin
        w_best       = P_NUM_REQ;
        w_dist       = 0;
        w_win_idx    = '0;
        w_win_onehot = '0;
        for (int i = 0; i < P_NUM_REQ; i++) begin
            w_dist = i - int'(last_q) - 1;
            if (w_dist < 0) begin
                w_dist = w_dist + P_NUM_REQ;
            end
            if (req_i[i] && (w_dist < w_best)) begin
                w_best    = w_dist;
                w_win_idx = IDX_W'(i);
            end
        end
        w_win_found = (w_best < P_NUM_REQ);
        for (int i = 0; i < P_NUM_REQ; i++) begin
            w_win_onehot[i] = w_win_found && (w_win_idx == IDX_W'(i));
        end
    end

    // Next-state logic for the IDLE -> SEND -> GAP frame sequencer.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gap_cnt_d   = gap_cnt_q;
        frame_cnt_d = frame_cnt_q;
        last_d      = last_q;
        case (state_q)
            ST_IDLE: begin
                if (w_win_found) begin
                    state_d = ST_SEND;
                    grant_d = w_win_onehot;
                    last_d  = w_win_idx;
                end
            end
            ST_SEND: begin
                // Only the granted queue's end-of-frame flag matters here.
                if (|(eof_i & grant_q)) begin
                    state_d     = ST_GAP;
                    grant_d     = '0;
                    gap_cnt_d   = IFG_LOAD;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            gap_cnt_q   <= 8'd0;
            frame_cnt_q <= 16'd0;
            last_q      <= LAST_RST;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gap_cnt_q   <= gap_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            last_q      <= last_d;
        end
    end

    // Outputs decode registered state only.
    always_comb begin
        grant_o     = grant_q;
        pop_o       = (state_q == ST_SEND) ? grant_q : '0;
        tx_ctrl_o   = (state_q == ST_SEND);
        busy_o      = (state_q == ST_SEND) || (state_q == ST_GAP);
        frame_cnt_o = frame_cnt_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_tx_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_frame_arbiter
// Description : Directed self-checking bench for tx_frame_arbiter. One
//               instance uses the default 12-cycle gap, a second uses a
//               1-cycle gap for minimum-frame and back-to-back scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_frame_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  req,  eof,  grant,  pop;
    logic        tx,   busy;
    logic [15:0] fcnt;
    logic [2:0]  req1, eof1, grant1, pop1;
    logic        tx1,  busy1;
    logic [15:0] fcnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tx_frame_arbiter #(.P_NUM_REQ(3), .P_IFG_CYCLES(12)) dut (
        .clk_i(clk), .rstn_i(rstn), .req_i(req), .eof_i(eof),
        .grant_o(grant), .pop_o(pop), .tx_ctrl_o(tx), .busy_o(busy),
        .frame_cnt_o(fcnt)
    );

    tx_frame_arbiter #(.P_NUM_REQ(3), .P_IFG_CYCLES(1)) dut1 (
        .clk_i(clk), .rstn_i(rstn), .req_i(req1), .eof_i(eof1),
        .grant_o(grant1), .pop_o(pop1), .tx_ctrl_o(tx1), .busy_o(busy1),
        .frame_cnt_o(fcnt1)
    );

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; req = '0; eof = '0; req1 = '0; eof1 = '0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; req = 3'b111; req1 = 3'b111; eof = '0; eof1 = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({grant, pop, tx, busy} !== 8'b0) begin
            errors++; $display("FAIL reset_outputs: got %b required 0", {grant, pop, tx, busy});
        end
        checks++;
        if (fcnt !== 16'd0) begin
            errors++; $display("FAIL reset_fcnt: got %0d required 0", fcnt);
        end
        checks++;
        if ({grant1, pop1, tx1, busy1, fcnt1} !== 24'b0) begin
            errors++; $display("FAIL reset_outputs1: got %h required 0", {grant1, pop1, tx1, busy1, fcnt1});
        end
        req = '0; req1 = '0; rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || grant !== 3'b000) begin
            errors++; $display("FAIL idle_no_req: got busy=%b grant=%b required 0/000", busy, grant);
        end
    endtask

    task automatic test_single_frame();
        int pops = 0;
        int txc  = 0;
        req = 3'b010;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            checks++;
            if (grant !== 3'b010) begin
                errors++; $display("FAIL single_grant[%0d]: got %b required 010", i, grant);
            end
            if (pop === 3'b010) pops++;
            if (tx === 1'b1) txc++;
            if (i == 1) req = 3'b000;
            eof = (i == 5) ? 3'b101 : (i == 64) ? 3'b010 : 3'b000;
        end
        checks++;
        if (pops != 64) begin
            errors++; $display("FAIL single_pops: got %0d required 64", pops);
        end
        checks++;
        if (txc != 64) begin
            errors++; $display("FAIL single_tx: got %0d required 64", txc);
        end
        for (int g = 1; g <= 12; g++) begin
            @(negedge clk);
            eof = '0;
            checks++;
            if ({grant, pop, tx, busy} !== 8'b0000_0001) begin
                errors++; $display("FAIL single_gap[%0d]: got %b required 00000001", g, {grant, pop, tx, busy});
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL single_idle: got busy=%b required 0", busy);
        end
        checks++;
        if (fcnt !== 16'd1) begin
            errors++; $display("FAIL single_fcnt: got %0d required 1", fcnt);
        end
    endtask

    task automatic test_contention();
        logic [2:0] order [4];
        order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
        do_reset();
        req = 3'b111;
        for (int f = 0; f < 4; f++) begin
            for (int i = 1; i <= 64; i++) begin
                @(negedge clk);
                checks++;
                if (grant !== order[f]) begin
                    errors++; $display("FAIL contention_grant[f%0d c%0d]: got %b required %b", f, i, grant, order[f]);
                end
                if (f == 3 && i == 1) req = 3'b000;
                eof = (i == 64) ? order[f] : 3'b000;
            end
            for (int g = 1; g <= 13; g++) begin
                @(negedge clk);
                eof = '0;
                checks++;
                if (grant !== 3'b000 || busy !== (g <= 12)) begin
                    errors++; $display("FAIL contention_gap[f%0d g%0d]: got grant=%b busy=%b required 000/%b", f, g, grant, busy, (g <= 12));
                end
            end
        end
        checks++;
        if (fcnt !== 16'd4) begin
            errors++; $display("FAIL contention_fcnt: got %0d required 4", fcnt);
        end
    endtask

    task automatic test_holdoff();
        int pops = 0;
        req = 3'b010;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            checks++;
            if (grant !== 3'b010 || tx !== 1'b1) begin
                errors++; $display("FAIL holdoff_send[%0d]: got grant=%b tx=%b required 010/1", i, grant, tx);
            end
            if (pop === 3'b010) pops++;
            if (i == 1) req = 3'b001;
            eof = (i == 20) ? 3'b010 : 3'b000;
        end
        checks++;
        if (pops != 20) begin
            errors++; $display("FAIL holdoff_pops: got %0d required 20", pops);
        end
        for (int g = 1; g <= 13; g++) begin
            @(negedge clk);
            eof = '0;
            checks++;
            if (grant !== 3'b000) begin
                errors++; $display("FAIL holdoff_gap[%0d]: got %b required 000", g, grant);
            end
        end
        @(negedge clk);
        checks++;
        if (grant !== 3'b001) begin
            errors++; $display("FAIL holdoff_next_grant: got %b required 001", grant);
        end
        eof = 3'b001; req = '0;
        @(negedge clk);
        eof = '0;
        repeat (13) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        req = 3'b010;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) req = 3'b000;
        end
        checks++;
        if (grant !== 3'b010 || tx !== 1'b1) begin
            errors++; $display("FAIL midrst_pre: got grant=%b tx=%b required 010/1", grant, tx);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({grant, pop, tx, busy} !== 8'b0 || fcnt !== 16'd0) begin
            errors++; $display("FAIL midrst_async: got %b fcnt=%0d required 0", {grant, pop, tx, busy}, fcnt);
        end
        @(negedge clk);
        checks++;
        if (pop !== 3'b000 || tx !== 1'b0) begin
            errors++; $display("FAIL midrst_hold: got pop=%b tx=%b required 000/0", pop, tx);
        end
        req = 3'b100; rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (grant !== 3'b100) begin
            errors++; $display("FAIL midrst_regrant: got %b required 100", grant);
        end
        eof = 3'b100; req = '0;
        @(negedge clk);
        eof = '0;
        repeat (13) @(negedge clk);
        checks++;
        if (fcnt !== 16'd1 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_after: got fcnt=%0d busy=%b required 1/0", fcnt, busy);
        end
    endtask

    task automatic test_min_frame();
        do_reset();
        req1 = 3'b001;
        @(negedge clk);
        checks++;
        if (grant1 !== 3'b001 || pop1 !== 3'b001 || tx1 !== 1'b1) begin
            errors++; $display("FAIL min_send: got %b/%b/%b required 001/001/1", grant1, pop1, tx1);
        end
        eof1 = 3'b001; req1 = 3'b010;
        @(negedge clk);
        eof1 = '0;
        checks++;
        if ({grant1, pop1, tx1, busy1} !== 8'b0000_0001) begin
            errors++; $display("FAIL min_gap: got %b required 00000001", {grant1, pop1, tx1, busy1});
        end
        @(negedge clk);
        checks++;
        if (busy1 !== 1'b0 || grant1 !== 3'b000) begin
            errors++; $display("FAIL min_idle: got busy=%b grant=%b required 0/000", busy1, grant1);
        end
        @(negedge clk);
        checks++;
        if (grant1 !== 3'b010) begin
            errors++; $display("FAIL min_next_grant: got %b required 010", grant1);
        end
        checks++;
        if (fcnt1 !== 16'd1) begin
            errors++; $display("FAIL min_fcnt: got %0d required 1", fcnt1);
        end
        eof1 = 3'b010; req1 = '0;
        @(negedge clk);
        eof1 = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_g = 3'b001;
        int grants   = 0;
        int last_cyc = -1;
        do_reset();
        req1 = 3'b111; eof1 = 3'b111;
        for (int c = 0; c < 1200 && grants < 300; c++) begin
            @(negedge clk);
            if (grant1 !== 3'b000) begin
                checks++;
                if (grant1 !== exp_g) begin
                    errors++; $display("FAIL b2b_grant[%0d]: got %b required %b", grants, grant1, exp_g);
                end
                if (last_cyc >= 0) begin
                    checks++;
                    if (c - last_cyc != 3) begin
                        errors++; $display("FAIL b2b_spacing[%0d]: got %0d required 3", grants, c - last_cyc);
                    end
                end
                last_cyc = c;
                grants++;
                exp_g = {exp_g[1:0], exp_g[2]};
                if (grants == 300) req1 = '0;
            end else begin
                checks++;
                if (pop1 !== 3'b000 || tx1 !== 1'b0) begin
                    errors++; $display("FAIL b2b_idle_out: got pop=%b tx=%b required 000/0", pop1, tx1);
                end
            end
        end
        checks++;
        if (grants != 300) begin
            errors++; $display("FAIL b2b_timeout: got %0d grants required 300", grants);
        end
        repeat (4) @(negedge clk);
        eof1 = '0;
        checks++;
        if (fcnt1 !== 16'd300) begin
            errors++; $display("FAIL b2b_fcnt: got %0d required 300", fcnt1);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_contention();
        test_holdoff();
        test_reset_mid_frame();
        test_min_frame();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/tx_frame_arbiter.md
TX_FRAME_ARBITER -- requirements
Module: tx_frame_arbiter

Interface
REQ-001 The block SHALL have parameter P_NUM_REQ, default 3, giving the number of virtual-channel queues competing for one TX port.
REQ-002 The block SHALL have parameter P_IFG_CYCLES, default 12, giving the idle cycles inserted after each frame; legal range is 1..255.
REQ-003 clk_i  input  1  single clock, all state updates on its rising edge.
REQ-004 rstn_i  input  1  asynchronous, active-low reset.
REQ-005 req_i  input  P_NUM_REQ  bit k high means queue k holds at least one complete frame.
REQ-006 eof_i  input  P_NUM_REQ  bit k high means the head byte of FWFT queue k is the last byte of its frame.
REQ-007 grant_o  output  P_NUM_REQ  one-hot grant for the queue currently being sent, or all zero.
REQ-008 pop_o  output  P_NUM_REQ  read enable to the queues; equal to grant_o while in SEND, otherwise zero.
REQ-009 tx_ctrl_o  output  1  high while a byte from the granted queue is valid on the TX port.
REQ-010 busy_o  output  1  high in SEND or GAP.
REQ-011 frame_cnt_o  output  16  count of completed frames, wrapping.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SEND and GAP.
REQ-013 IDLE behaviour:
- If req_i is nonzero at edge N, the block SHALL register a one-hot grant and enter SEND.
- grant_o SHALL be visible from cycle N+1.
- The winner SHALL be the first requester found searching upward from (last_winner+1) mod P_NUM_REQ.
REQ-014 last_winner SHALL be updated to the index of the granted queue at the moment the grant is registered.
REQ-015 SEND behaviour:
- grant_o SHALL be held constant.
- pop_o SHALL equal grant_o.
- tx_ctrl_o SHALL be 1 every cycle.
REQ-016 In SEND, req_i changes SHALL be ignored, including deassertion of the granted bit; a frame is never aborted or interleaved.
REQ-017 In SEND, eof_i bits of non-granted queues SHALL be ignored.
REQ-018 EOF handling: when eof_i is high for the granted queue at edge M in SEND, that edge SHALL have the following effects:
- The last byte is popped.
- The state becomes GAP.
- grant_o clears.
- The gap counter loads P_IFG_CYCLES-1.
- frame_cnt_o increments, wrapping 0xFFFF to 0x0000.
REQ-019 GAP behaviour:
- pop_o, grant_o and tx_ctrl_o SHALL be 0.
- The counter SHALL decrement each cycle.
- When the counter is 0, the next edge SHALL enter IDLE.
- GAP SHALL therefore last exactly P_IFG_CYCLES cycles.
REQ-020 Earliest next grant after EOF at edge M SHALL be visible at cycle M+P_IFG_CYCLES+2.
REQ-021 A one-byte frame (eof_i high on the first SEND cycle) SHALL produce exactly one pop and one tx_ctrl_o cycle.
REQ-022 Requests arriving during GAP SHALL be held off and arbitrated only in IDLE.
REQ-023 The gap counter width SHALL be 8 bits.
REQ-024 grant_o SHALL never have more than one bit set.
REQ-025 All outputs SHALL be driven from registered state only, with no combinational path from req_i or eof_i to any output.

Reset
REQ-026 On rstn_i low, the block SHALL immediately, independent of clk_i, apply these values:
- State IDLE.
- grant_o, pop_o, tx_ctrl_o and busy_o at 0.
- frame_cnt_o at 0.
- Gap counter at 0.
- last_winner at P_NUM_REQ-1, so that queue 0 has first priority.
REQ-027 Reset asserted mid-frame or mid-gap SHALL abandon the frame with no further pops.
REQ-028 After rstn_i rises, the first grant SHALL follow REQ-013 from the reset priority.

Verification
REQ-029 Single frame: req_i=3'b010, eof on the 64th SEND cycle. Required response:
- grant_o=3'b010 for 64 cycles.
- 64 pops.
- tx_ctrl_o high for 64 cycles, then low for 12.
- frame_cnt_o=1.
REQ-030 Contention: req_i=3'b111 held, each frame 64 bytes. Required response:
- Grant order 001, 010, 100, 001.
- Each grant separated by 12 idle cycles.
REQ-031 Hold-off: req_i=3'b001 during SEND of queue 1, and the queue 1 request drops mid-frame. Required response:
- Queue 1 still sends all bytes up to eof.
- Queue 0 is granted at M+14.
REQ-032 Minimum frame: a 1-byte frame and P_IFG_CYCLES=1. Required response:
- One pop.
- GAP lasts 1 cycle.
- Next grant at M+3.
REQ-033 Reset mid-frame: rstn_i pulled low on the 10th SEND cycle. Required response:
- All outputs are 0 within the same cycle.
- After release with req_i=3'b100, grant_o=3'b100.
REQ-034 Counter wrap: 65536 one-byte frames sent. Required response: frame_cnt_o returns to 0x0000 and no grant is lost.
